// File: rtl/ysyx_24070016_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24070016_mem_arbiter
//
// Shares one downstream memory port between the instruction-fetch requester
// (IF) and the load/store requester (LS). Only one transaction is in flight
// at a time. Each transaction moves through the issue, wait and response
// phases.
//
// Ports
//   clk, rst            system clock; synchronous active-high reset
//   if_req_*            IF request channel (valid/ready/addr)
//   if_resp_*           IF response channel (valid/ready/rdata/err)
//   ls_req_*            LS request channel (valid/ready/addr/wen/wdata/wmask)
//   ls_resp_*           LS response channel (valid/ready/rdata/err)
//   mem_req_*           downstream request (valid/ready/addr/wen/wdata/wmask)
//   mem_resp_*          downstream response (valid/rdata), one per request
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH  bus widths
//   TIMEOUT_CYCLES          WAIT cycles before a forced error response (>= 1)
//
// Optional build macro
//   YSYX_24070016_ARB_RR_EN  round-robin arbitration between IF and LS.
//                            When it is undefined, LS has fixed priority
//                            over IF.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | accept one request; requester ready is combinational
// ISSUE  | mem_req_valid high from latched registers until mem_req_ready
// WAIT   | wait for mem_resp_valid; count toward the timeout
// RESP   | granted requester sees resp_valid until its resp_ready
// ---------------------------------------------------------------------------
module ysyx_24070016_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_resp_valid,
  input  logic                    if_resp_ready,
  output logic [DATA_WIDTH-1:0]   if_resp_rdata,
  output logic                    if_resp_err,

  input  logic                    ls_req_valid,
  output logic                    ls_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
  input  logic                    ls_req_wen,
  input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_req_wmask,
  output logic                    ls_resp_valid,
  input  logic                    ls_resp_ready,
  output logic [DATA_WIDTH-1:0]   ls_resp_rdata,
  output logic                    ls_resp_err,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  // The counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]              state_q, state_d;
  logic                    grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wmask_q, wmask_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic idle;
  logic ls_prio;
  logic sel_ls;
  logic if_hs;
  logic ls_hs;
  logic resp_if;
  logic resp_ls;

`ifdef YSYX_24070016_ARB_RR_EN
  logic last_q, last_d;
  // Reset value is IF, so LS wins the first tie after reset.
  assign ls_prio = (last_q == GRANT_IF);
`else
  assign ls_prio = 1'b1;
`endif

  assign idle   = (state_q == IDLE);
  assign sel_ls = ls_req_valid && (!if_req_valid || ls_prio);

  assign ls_req_ready = idle && sel_ls;
  assign if_req_ready = idle && if_req_valid && !sel_ls;
  assign ls_hs        = ls_req_ready;
  assign if_hs        = if_req_ready;

  assign resp_if = (state_q == RESP) && (grant_q == GRANT_IF);
  assign resp_ls = (state_q == RESP) && (grant_q == GRANT_LS);

  assign if_resp_valid = resp_if;
  assign ls_resp_valid = resp_ls;
  assign if_resp_rdata = rdata_q;
  assign ls_resp_rdata = rdata_q;
  // err_q is not cleared after a timeout, so qualify it with the grant.
  assign if_resp_err   = resp_if && err_q;
  assign ls_resp_err   = resp_ls && err_q;

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef YSYX_24070016_ARB_RR_EN
    last_d  = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (ls_hs) begin
          addr_d  = ls_req_addr;
          wen_d   = ls_req_wen;
          wdata_d = ls_req_wdata;
          wmask_d = ls_req_wmask;
          grant_d = GRANT_LS;
          state_d = ISSUE;
`ifdef YSYX_24070016_ARB_RR_EN
          last_d  = GRANT_LS;
`endif
        end else if (if_hs) begin
          // Fetches are always reads.
          addr_d  = if_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          grant_d = GRANT_IF;
          state_d = ISSUE;
`ifdef YSYX_24070016_ARB_RR_EN
          last_d  = GRANT_IF;
`endif
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = wen_q ? '0 : mem_resp_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if ((grant_q == GRANT_LS) ? ls_resp_ready : if_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GRANT_IF;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef YSYX_24070016_ARB_RR_EN
      last_q  <= GRANT_IF;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef YSYX_24070016_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_24070016_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24070016_mem_arbiter
//
// Directed bench for the IF/LS memory arbiter. The arbiter is built with
// TIMEOUT_CYCLES=4. Inputs change 1 time unit after a rising edge, and
// outputs are checked 2 time units later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_ysyx_24070016_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_resp_valid, if_resp_ready, if_resp_err;
  logic [DW-1:0] if_resp_rdata;
  logic          ls_req_valid, ls_req_ready, ls_req_wen;
  logic [AW-1:0] ls_req_addr;
  logic [DW-1:0] ls_req_wdata;
  logic [3:0]    ls_req_wmask;
  logic          ls_resp_valid, ls_resp_ready, ls_resp_err;
  logic [DW-1:0] ls_resp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [3:0]    mem_req_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_24070016_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
    .if_resp_rdata(if_resp_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready),
    .ls_resp_rdata(ls_resp_rdata), .ls_resp_err(ls_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 0; if_req_addr = '0; if_resp_ready = 0;
    ls_req_valid = 0; ls_req_addr = '0; ls_req_wen = 0;
    ls_req_wdata = '0; ls_req_wmask = '0; ls_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    settle();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_if_resp_valid", if_resp_valid, 0);
    chk("rst_ls_resp_valid", ls_resp_valid, 0);
    chk("rst_if_req_ready", if_req_ready, 0);
    chk("rst_ls_req_ready", ls_req_ready, 0);
    chk("rst_rdata", if_resp_rdata, 0);
    chk("rst_errs", {if_resp_err, ls_resp_err}, 0);
    chk("rst_mem_req_payload", {mem_req_addr, mem_req_wen, mem_req_wmask}, 0);
    chk("rst_mem_req_wdata", mem_req_wdata, 0);

    tick();
    rst = 1'b0;

    // ---------------- single IF read ----------------
    tick();
    if_req_valid = 1; if_req_addr = 32'h8000_0000;
    settle();
    chk("t1_if_req_ready", if_req_ready, 1);
    chk("t1_ls_req_ready", ls_req_ready, 0);
    tick();                       // T+1
    if_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("t1_mem_req_valid", mem_req_valid, 1);
    chk("t1_mem_req_addr", mem_req_addr, 32'h8000_0000);
    chk("t1_mem_req_wen_wmask", {mem_req_wen, mem_req_wmask}, 0);
    tick();                       // T+2
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413;
    settle();
    chk("t1_mem_req_valid_drop", mem_req_valid, 0);
    chk("t1_if_resp_early", if_resp_valid, 0);
    tick();                       // T+3
    mem_resp_valid = 0;
    settle();
    chk("t1_if_resp_valid", if_resp_valid, 1);
    chk("t1_if_resp_rdata", if_resp_rdata, 32'h0000_0413);
    chk("t1_if_resp_err", if_resp_err, 0);
    chk("t1_ls_resp_valid", ls_resp_valid, 0);
    if_resp_ready = 1;
    tick();
    if_resp_ready = 0;
    settle();
    chk("t1_if_resp_done", if_resp_valid, 0);

    // ---------------- simultaneous requests ----------------
    if_req_valid = 1; if_req_addr = 32'h8000_0004;
    ls_req_valid = 1; ls_req_addr = 32'h8000_1000; ls_req_wen = 0;
    settle();
    chk("t2_ls_wins_ready", ls_req_ready, 1);
    chk("t2_if_loses_ready", if_req_ready, 0);
    tick();
    ls_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("t2_first_addr", mem_req_addr, 32'h8000_1000);
    chk("t2_if_ready_issue", if_req_ready, 0);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h1111_1111;
    tick();
    mem_resp_valid = 0;
    settle();
    chk("t2_ls_resp_valid", ls_resp_valid, 1);
    chk("t2_ls_resp_rdata", ls_resp_rdata, 32'h1111_1111);
    chk("t2_if_resp_quiet", if_resp_valid, 0);
    chk("t2_if_ready_resp", if_req_ready, 0);
    ls_resp_ready = 1;
    tick();
    ls_resp_ready = 0;
    settle();
    chk("t2_if_ready_second", if_req_ready, 1);
    tick();
    if_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("t2_second_addr", mem_req_addr, 32'h8000_0004);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h2222_2222;
    tick();
    mem_resp_valid = 0;
    settle();
    chk("t2_if_resp_rdata", {if_resp_valid, if_resp_rdata}, {1'b1, 32'h2222_2222});
    if_resp_ready = 1;
    tick();
    if_resp_ready = 0;

    // ---------------- LS write with request backpressure ----------------
    ls_req_valid = 1; ls_req_addr = 32'h8000_2000; ls_req_wen = 1;
    ls_req_wdata = 32'hDEAD_BEEF; ls_req_wmask = 4'hF;
    settle();
    chk("t3_ls_req_ready", ls_req_ready, 1);
    tick();
    // Payload changes after the handshake must not reach the memory port.
    ls_req_valid = 0; ls_req_addr = 32'h0BAD_0BAD; ls_req_wdata = 32'h0;
    ls_req_wmask = 4'h0; ls_req_wen = 0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      settle();
      chk("t3_mem_req_valid", mem_req_valid, 1);
      chk("t3_mem_req_addr", mem_req_addr, 32'h8000_2000);
      chk("t3_mem_req_wdata", mem_req_wdata, 32'hDEAD_BEEF);
      chk("t3_mem_req_wen_wmask", {mem_req_wen, mem_req_wmask}, 5'h1F);
      tick();
    end
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_F00D;
    tick();
    mem_resp_valid = 0;
    settle();
    chk("t3_ls_resp_valid", ls_resp_valid, 1);
    chk("t3_ls_resp_rdata_zero", ls_resp_rdata, 0);
    chk("t3_ls_resp_err", ls_resp_err, 0);
    ls_resp_ready = 1;
    tick();
    ls_resp_ready = 0;

`ifdef YSYX_24070016_ARB_RR_EN
    // ---------------- round-robin tie: LS was granted last ----------------
    if_req_valid = 1; if_req_addr = 32'h8000_0008;
    ls_req_valid = 1; ls_req_addr = 32'h8000_1004; ls_req_wen = 0;
    settle();
    chk("rr_if_wins", {if_req_ready, ls_req_ready}, 2'b10);
    tick();
    if_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("rr_first_addr", mem_req_addr, 32'h8000_0008);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h3333_3333;
    tick();
    mem_resp_valid = 0; if_resp_ready = 1;
    tick();
    if_resp_ready = 0;
    settle();
    chk("rr_ls_next", ls_req_ready, 1);
    tick();
    ls_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("rr_second_addr", mem_req_addr, 32'h8000_1004);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h4444_4444;
    tick();
    mem_resp_valid = 0; ls_resp_ready = 1;
    tick();
    ls_resp_ready = 0;
`endif

    // ---------------- timeout (TIMEOUT_CYCLES = 4) ----------------
    ls_req_valid = 1; ls_req_addr = 32'h8000_3000; ls_req_wen = 0;
    settle();
    chk("t4_ls_req_ready", ls_req_ready, 1);
    tick();
    ls_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t4_no_resp_in_wait", ls_resp_valid, 0);
      tick();
    end
    settle();
    chk("t4_ls_resp_valid", ls_resp_valid, 1);
    chk("t4_ls_resp_err", ls_resp_err, 1);
    chk("t4_ls_resp_rdata", ls_resp_rdata, 0);
    chk("t4_if_resp_quiet", {if_resp_valid, if_resp_err}, 0);
    mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
    tick();
    settle();
    chk("t4_late_resp_dropped", {ls_resp_valid, ls_resp_err, ls_resp_rdata},
        {1'b1, 1'b1, 32'h0});
    ls_resp_ready = 1;
    tick();
    ls_resp_ready = 0;
    settle();
    chk("t4_idle_ignores_resp", {ls_resp_valid, mem_req_valid}, 0);
    mem_resp_valid = 0;

    // ---------------- response backpressure ----------------
    if_req_valid = 1; if_req_addr = 32'h8000_4000;
    settle();
    chk("t5_if_req_ready", if_req_ready, 1);
    tick();
    if_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h55AA_55AA;
    tick();
    mem_resp_valid = 0;
    ls_req_valid = 1; ls_req_addr = 32'h8000_5000; ls_req_wen = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_if_resp_held", {if_resp_valid, if_resp_rdata}, {1'b1, 32'h55AA_55AA});
      chk("t5_ls_req_blocked", ls_req_ready, 0);
      tick();
    end
    if_resp_ready = 1;
    settle();
    chk("t5_ls_blocked_at_hs", ls_req_ready, 0);
    tick();
    if_resp_ready = 0;
    settle();
    chk("t5_if_resp_released", if_resp_valid, 0);
    chk("t5_ls_req_ready_after", ls_req_ready, 1);
    tick();
    ls_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("t5_ls_addr", mem_req_addr, 32'h8000_5000);
    tick();
    mem_req_ready = 0;

    // ---------------- reset while in WAIT ----------------
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("t6_valids_zero", {mem_req_valid, if_resp_valid, ls_resp_valid}, 0);
    chk("t6_readys_zero", {if_req_ready, ls_req_ready}, 0);
    chk("t6_mem_addr_zero", mem_req_addr, 0);
    if_req_valid = 1; if_req_addr = 32'h8000_6000;
    settle();
    chk("t6_if_req_ready", if_req_ready, 1);
    tick();
    if_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("t6_if_addr", {mem_req_valid, mem_req_addr}, {1'b1, 32'h8000_6000});
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h7777_7777;
    tick();
    mem_resp_valid = 0;
    settle();
    chk("t6_if_resp", {if_resp_valid, if_resp_err, if_resp_rdata},
        {1'b1, 1'b0, 32'h7777_7777});
    if_resp_ready = 1;
    tick();
    if_resp_ready = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
